jtkunio_sndcmd: RTL and testbench

JTKUNIO_SNDCMD -- requirements
Module: jtkunio_sndcmd

---
 rtl/jtkunio_sndcmd.sv | 140 ++++++++++++++
 tb/tb_jtkunio_sndcmd.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtkunio_sndcmd.sv
// Purpose     : sound-command mailbox from the main CPU to the sound CPU.
// Latency     : push lands 1 clk after the snd_irq rising edge; pop takes effect on the read's cen edge.
// Backpressure: none; a push that finds no room is lost and flagged on ovf.
//
// Build option: define JTKUNIO_SNDFIFO_EN for a 4-entry circular queue.
// Without it, a single 8-bit latch is used and a second push overwrites it.
//
// Ports
//   clk, rst   24 MHz clock, synchronous active-high reset
//   cen        sound CPU clock enable (one clk wide)
//   snd_irq    main CPU write strobe (level); snd_latch is its byte
//   latch_cs   sound CPU access to the command port; cpu_rnw = 1 for reads
//   ovf_clr    clears the sticky overflow flag
//   dout       byte at the head of the queue, or the last popped byte when empty
//   irqn       active-low interrupt to the sound CPU, registered
//   pending    at least one command unread
//   level      number of queued commands
//   ovf        sticky: a command was lost
module jtkunio_sndcmd (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic       snd_irq,
    input  logic [7:0] snd_latch,
    input  logic       latch_cs,
    input  logic       cpu_rnw,
    input  logic       ovf_clr,
    output logic [7:0] dout,
    output logic       irqn,
    output logic       pending,
    output logic [2:0] level,
    output logic       ovf
);

    logic       irq_l;      // snd_irq one clk ago
    logic       push;       // push request, one clk after the rising edge
    logic [7:0] push_dat;   // byte captured on the rising-edge cycle
    logic       rd_done;    // the current read access has already been served
    logic       rd_now;     // first cen of a read access
    logic       do_pop;

    assign rd_now  = cen & latch_cs & cpu_rnw & ~rd_done;
    assign pending = (level != 3'd0);
    assign do_pop  = rd_now & pending;

    // Strobe edge detector and read-access tracker.
    // On reset both trackers take the current input level rather than zero:
    // a strobe or read access already in progress when rst falls must not be
    // seen as a new one, while an edge arriving after reset still counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_l    <= snd_irq;
            push     <= 1'b0;
            push_dat <= 8'h00;
            rd_done  <= latch_cs;
            irqn     <= 1'b1;
        end else begin
            irq_l    <= snd_irq;
            push     <= snd_irq & ~irq_l;
            push_dat <= snd_latch;
            // an empty-queue read still consumes the access
            rd_done  <= latch_cs & (rd_done | rd_now);
            irqn     <= ~pending;
        end
    end

`ifdef JTKUNIO_SNDFIFO_EN
    logic [7:0] mem [0:3];
    logic [1:0] rd_ptr;
    logic [1:0] wr_ptr;
    logic [7:0] last;       // last popped byte, shown while empty
    logic       full;
    logic       wr_en;

    assign full  = (level == 3'd4);
    // when full, a simultaneous pop frees the slot wr_ptr points at
    assign wr_en = push & (~full | do_pop);
    assign dout  = pending ? mem[rd_ptr] : last;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= 2'd0;
            wr_ptr <= 2'd0;
            level  <= 3'd0;
            last   <= 8'h00;
            ovf    <= 1'b0;
        end else begin
            if (do_pop) begin
                rd_ptr <= rd_ptr + 2'd1;
                last   <= mem[rd_ptr];
            end
            if (wr_en) begin
                wr_ptr <= wr_ptr + 2'd1;
            end
            if (wr_en && !do_pop) begin
                level <= level + 3'd1;
            end else if (do_pop && !wr_en) begin
                level <= level - 3'd1;
            end
            if (push && full && !do_pop) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end
`else
    logic [7:0] hold;       // the single command latch; keeps its byte after a pop

    assign dout = hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            hold  <= 8'h00;
            level <= 3'd0;
            ovf   <= 1'b0;
        end else begin
            if (push) begin
                hold  <= push_dat;
                level <= 3'd1;
            end else if (do_pop) begin
                level <= 3'd0;
            end
            // overwrite of an unread byte loses it, unless it is read this cycle
            if (push && pending && !do_pop) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_jtkunio_sndcmd.sv
module tb_jtkunio_sndcmd;

`ifdef JTKUNIO_SNDFIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif

    logic       clk = 1'b0;
    logic       rst, cen, snd_irq, latch_cs, cpu_rnw, ovf_clr;
    logic [7:0] snd_latch;
    logic [7:0] dout;
    logic       irqn, pending, ovf;
    logic [2:0] level;

    jtkunio_sndcmd dut (
        .clk       (clk),
        .rst       (rst),
        .cen       (cen),
        .snd_irq   (snd_irq),
        .snd_latch (snd_latch),
        .latch_cs  (latch_cs),
        .cpu_rnw   (cpu_rnw),
        .ovf_clr   (ovf_clr),
        .dout      (dout),
        .irqn      (irqn),
        .pending   (pending),
        .level     (level),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model: a byte queue of capacity DEPTH ----------------
    logic [7:0] mq[$];
    logic [7:0] m_last = 8'h00;
    logic       m_ovf = 1'b0, m_irqn = 1'b1;
    logic       m_prev_irq = 1'b0, m_pend = 1'b0, m_used = 1'b0;
    logic [7:0] m_pend_dat = 8'h00;

    always @(posedge clk) begin : model
        logic want_pop, lost;
        if (rst) begin
            mq.delete();
            m_last     = 8'h00;
            m_ovf      = 1'b0;
            m_irqn     = 1'b1;
            m_pend     = 1'b0;
            m_prev_irq = snd_irq;
            m_used     = latch_cs;
        end else begin
            m_irqn   = (mq.size() == 0);
            want_pop = cen && latch_cs && cpu_rnw && !m_used;
            if (!latch_cs)
                m_used = 1'b0;
            else if (want_pop)
                m_used = 1'b1;
            lost = 1'b0;
            if (want_pop && mq.size() > 0)
                m_last = mq.pop_front();
            if (m_pend) begin
                if (mq.size() < DEPTH) begin
                    mq.push_back(m_pend_dat);
                end else begin
                    lost = 1'b1;
                    if (DEPTH == 1) mq[0] = m_pend_dat;
                end
            end
            if (lost) m_ovf = 1'b1;
            else if (ovf_clr) m_ovf = 1'b0;
            m_pend     = snd_irq && !m_prev_irq;
            m_pend_dat = snd_latch;
            m_prev_irq = snd_irq;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_level",   {5'd0, level},   8'(mq.size()));
            check("model_dout",    dout,            (mq.size() > 0) ? mq[0] : m_last);
            check("model_irqn",    {7'd0, irqn},    {7'd0, m_irqn});
            check("model_pending", {7'd0, pending}, {7'd0, (mq.size() > 0)});
            check("model_ovf",     {7'd0, ovf},     {7'd0, m_ovf});
        end
    end

    // ---------------- directed vectors: one row = one clk ----------------
    typedef struct {
        logic       rst, irq;
        logic [7:0] dat;
        logic       cs, rnw, cen, clr;
        logic [2:0] lvl;
        logic [7:0] dout;
        logic       irqn, ovf;
    } vec_t;

    localparam int NV = 27;
    vec_t tbl[NV];

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_b(input logic [7:0] d);
        snd_irq = 1'b1; snd_latch = d; cyc(3);
        snd_irq = 1'b0; snd_latch = 8'h00; cyc(2);
    endtask

    // one read access of 5 clk spanning a single cen; v is the byte on the bus
    task automatic read_b(output logic [7:0] v);
        latch_cs = 1'b1; cpu_rnw = 1'b1; cen = 1'b0; cyc(1);
        v = dout;
        cen = 1'b1; cyc(1);
        cen = 1'b0; cyc(2);
        latch_cs = 1'b0; cyc(1);
    endtask

    localparam logic [2:0] LVL_FULL = 3'(DEPTH);
    localparam logic [2:0] LVL_TWO  = (DEPTH >= 2) ? 3'd2 : 3'd1;

    initial begin
        logic [7:0] v;
        rst = 1'b1; cen = 1'b0; snd_irq = 1'b0; snd_latch = 8'h00;
        latch_cs = 1'b0; cpu_rnw = 1'b0; ovf_clr = 1'b0;

        //            rst  irq  dat    cs   rnw  cen  clr   lvl  dout   irqn ovf
        tbl[0]  = '{1'b1,1'b0,8'h00,1'b0,1'b0,1'b0,1'b0, 3'd0,8'h00,1'b1,1'b0};
        tbl[1]  = '{1'b1,1'b0,8'h00,1'b0,1'b0,1'b0,1'b0, 3'd0,8'h00,1'b1,1'b0};
        tbl[2]  = '{1'b0,1'b1,8'h5A,1'b0,1'b0,1'b0,1'b0, 3'd0,8'h00,1'b1,1'b0};
        tbl[3]  = '{1'b0,1'b1,8'h00,1'b0,1'b0,1'b0,1'b0, 3'd1,8'h5A,1'b1,1'b0};
        tbl[4]  = '{1'b0,1'b1,8'h00,1'b0,1'b0,1'b0,1'b0, 3'd1,8'h5A,1'b0,1'b0};
        tbl[5]  = '{1'b0,1'b0,8'h00,1'b0,1'b0,1'b0,1'b0, 3'd1,8'h5A,1'b0,1'b0};
        tbl[6]  = '{1'b0,1'b0,8'h00,1'b1,1'b1,1'b0,1'b0, 3'd1,8'h5A,1'b0,1'b0};
        tbl[7]  = '{1'b0,1'b0,8'h00,1'b1,1'b1,1'b1,1'b0, 3'd0,8'h5A,1'b0,1'b0};
        tbl[8]  = '{1'b0,1'b0,8'h00,1'b1,1'b1,1'b1,1'b0, 3'd0,8'h5A,1'b1,1'b0};
        tbl[9]  = '{1'b0,1'b0,8'h00,1'b0,1'b0,1'b0,1'b0, 3'd0,8'h5A,1'b1,1'b0};
        tbl[10] = '{1'b0,1'b1,8'h33,1'b1,1'b0,1'b1,1'b0, 3'd0,8'h5A,1'b1,1'b0};
        tbl[11] = '{1'b0,1'b0,8'h00,1'b1,1'b0,1'b1,1'b0, 3'd1,8'h33,1'b1,1'b0};
        tbl[12] = '{1'b0,1'b0,8'h00,1'b0,1'b0,1'b0,1'b0, 3'd1,8'h33,1'b0,1'b0};
        tbl[13] = '{1'b0,1'b1,8'h44,1'b1,1'b1,1'b1,1'b0, 3'd0,8'h33,1'b0,1'b0};
        tbl[14] = '{1'b0,1'b0,8'h00,1'b1,1'b1,1'b0,1'b0, 3'd1,8'h44,1'b1,1'b0};
        tbl[15] = '{1'b0,1'b1,8'h55,1'b0,1'b0,1'b0,1'b0, 3'd1,8'h44,1'b0,1'b0};
        tbl[16] = '{1'b0,1'b1,8'h00,1'b1,1'b1,1'b1,1'b0, 3'd1,8'h55,1'b0,1'b0};
        tbl[17] = '{1'b0,1'b0,8'h00,1'b0,1'b0,1'b0,1'b0, 3'd1,8'h55,1'b0,1'b0};
        tbl[18] = '{1'b1,1'b1,8'h66,1'b0,1'b0,1'b0,1'b0, 3'd0,8'h00,1'b1,1'b0};
        tbl[19] = '{1'b0,1'b1,8'h66,1'b0,1'b0,1'b0,1'b0, 3'd0,8'h00,1'b1,1'b0};
        tbl[20] = '{1'b0,1'b1,8'h66,1'b0,1'b0,1'b0,1'b0, 3'd0,8'h00,1'b1,1'b0};
        tbl[21] = '{1'b0,1'b0,8'h00,1'b0,1'b0,1'b0,1'b0, 3'd0,8'h00,1'b1,1'b0};
        tbl[22] = '{1'b1,1'b0,8'h00,1'b1,1'b1,1'b0,1'b0, 3'd0,8'h00,1'b1,1'b0};
        tbl[23] = '{1'b0,1'b1,8'h77,1'b1,1'b1,1'b0,1'b0, 3'd0,8'h00,1'b1,1'b0};
        tbl[24] = '{1'b0,1'b1,8'h00,1'b1,1'b1,1'b0,1'b0, 3'd1,8'h77,1'b1,1'b0};
        tbl[25] = '{1'b0,1'b0,8'h00,1'b1,1'b1,1'b1,1'b0, 3'd1,8'h77,1'b0,1'b0};
        tbl[26] = '{1'b0,1'b0,8'h00,1'b0,1'b0,1'b0,1'b0, 3'd1,8'h77,1'b0,1'b0};

        cyc(1);
        chk_en = 1'b1;
        for (int i = 0; i < NV; i++) begin
            rst = tbl[i].rst; snd_irq = tbl[i].irq; snd_latch = tbl[i].dat;
            latch_cs = tbl[i].cs; cpu_rnw = tbl[i].rnw; cen = tbl[i].cen; ovf_clr = tbl[i].clr;
            cyc(1);
            check($sformatf("vec%0d_level", i),   {5'd0, level},   {5'd0, tbl[i].lvl});
            check($sformatf("vec%0d_dout", i),    dout,            tbl[i].dout);
            check($sformatf("vec%0d_irqn", i),    {7'd0, irqn},    {7'd0, tbl[i].irqn});
            check($sformatf("vec%0d_pending", i), {7'd0, pending}, {7'd0, (tbl[i].lvl != 3'd0)});
            check($sformatf("vec%0d_ovf", i),     {7'd0, ovf},     {7'd0, tbl[i].ovf});
        end
        rst = 1'b0; snd_irq = 1'b0; latch_cs = 1'b0; cpu_rnw = 1'b0; cen = 1'b0; ovf_clr = 1'b0;

        // long strobe: exactly one push
        rst = 1'b1; cyc(2); rst = 1'b0; cyc(1);
        snd_irq = 1'b1; snd_latch = 8'h5A; cyc(20);
        check("long_strobe_level", {5'd0, level}, 8'd1);
        check("long_strobe_irqn",  {7'd0, irqn},  8'd0);
        check("long_strobe_dout",  dout,          8'h5A);
        snd_irq = 1'b0; cyc(2);
        read_b(v);
        check("long_strobe_read", v, 8'h5A);

        // overflow: five pushes, no reads
        rst = 1'b1; cyc(2); rst = 1'b0; cyc(1);
        for (int i = 0; i < 5; i++) push_b(8'h10 + 8'(i));
        check("ovf_level", {5'd0, level}, {5'd0, LVL_FULL});
        check("ovf_flag",  {7'd0, ovf},   8'd1);
        for (int i = 0; i < DEPTH; i++) begin
            read_b(v);
            check($sformatf("ovf_read%0d", i), v, (DEPTH == 4) ? 8'h10 + 8'(i) : 8'h14);
        end
        check("drain_level", {5'd0, level}, 8'd0);
        check("drain_irqn",  {7'd0, irqn},  8'd1);
        check("drain_dout",  dout,          (DEPTH == 4) ? 8'h13 : 8'h14);
        ovf_clr = 1'b1; cyc(1); ovf_clr = 1'b0; cyc(1);
        check("ovf_clr", {7'd0, ovf}, 8'd0);

        // push and pop on the same clk while full
        for (int i = 0; i < DEPTH; i++) push_b(8'h20 + 8'(i));
        snd_irq = 1'b1; snd_latch = 8'hAA; cyc(1);
        latch_cs = 1'b1; cpu_rnw = 1'b1; cen = 1'b1; cyc(1);
        cen = 1'b0; snd_irq = 1'b0;
        check("full_pushpop_level", {5'd0, level}, {5'd0, LVL_FULL});
        check("full_pushpop_ovf",   {7'd0, ovf},   8'd0);
        cyc(1); latch_cs = 1'b0; cyc(2);
        for (int i = 0; i < DEPTH - 1; i++) read_b(v);
        check("full_pushpop_head",  dout,          8'hAA);
        check("full_pushpop_left",  {5'd0, level}, 8'd1);
        read_b(v);

        // a held read access pops once; a held write access never pops
        push_b(8'h30); push_b(8'h31);
        check("hold_level_before", {5'd0, level}, {5'd0, LVL_TWO});
        latch_cs = 1'b1; cpu_rnw = 1'b1;
        repeat (3) begin cen = 1'b1; cyc(1); cen = 1'b0; cyc(3); end
        latch_cs = 1'b0; cyc(1);
        check("hold_read_level", {5'd0, level}, {5'd0, LVL_TWO - 3'd1});
        check("hold_read_dout",  dout,          8'h31);
        push_b(8'h32);
        latch_cs = 1'b1; cpu_rnw = 1'b0;
        repeat (3) begin cen = 1'b1; cyc(1); cen = 1'b0; cyc(3); end
        latch_cs = 1'b0; cyc(1);
        check("hold_write_level", {5'd0, level}, {5'd0, LVL_TWO});

        // reset in the middle of a strobe
        snd_irq = 1'b1; snd_latch = 8'h99; cyc(1);
        rst = 1'b1; cyc(2);
        check("midrst_level", {5'd0, level}, 8'd0);
        check("midrst_dout",  dout,          8'h00);
        check("midrst_irqn",  {7'd0, irqn},  8'd1);
        check("midrst_ovf",   {7'd0, ovf},   8'd0);
        rst = 1'b0; cyc(5);
        check("midrst_nopush", {5'd0, level}, 8'd0);
        snd_irq = 1'b0; cyc(2);

        // randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 5) == 0) snd_irq = ~snd_irq;
            snd_latch = 8'($urandom);
            if ($urandom_range(0, 4) == 0) begin
                latch_cs = ~latch_cs;
                if (latch_cs) cpu_rnw = ($urandom_range(0, 3) != 0);
            end
            cen = ($urandom_range(0, 3) == 0);
            ovf_clr = ($urandom_range(0, 40) == 0);
            cyc(1);
        end
        chk_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
